// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants, default widths and hold-counter type for pipe_stage_reg.
package pipe_pkg;
  localparam int DEF_INST_W   = 16;
  localparam int DEF_PC_W     = 16;
  localparam int DEF_SRC_W    = 16;
  localparam int DEF_NSRC     = 2;
  localparam int DEF_HIST     = 2;
  localparam int DEF_CNT_W    = 4;
  localparam int DEF_HOLD_MAX = 8;
  localparam logic [DEF_INST_W-1:0] NOP_INST = '0;
  typedef logic [DEF_CNT_W-1:0] hold_cnt_t;
endpackage

// File: rtl/pipe_field_reg.sv
// pipe_field_reg: one payload field; async active-low reset, sync clear to CLR, load on wen.
module pipe_field_reg #(
  parameter int W = 1,
  parameter logic [W-1:0] CLR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wen,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (clr) q <= CLR;
    else if (wen) q <= d;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline boundary register with flush history, hold counter and
// optional stall/bubble counters (enabled by defining PIPE_STATS_EN).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int INST_W   = DEF_INST_W,
  parameter int PC_W     = DEF_PC_W,
  parameter int SRC_W    = DEF_SRC_W,
  parameter int NSRC     = DEF_NSRC,
  parameter int HIST     = DEF_HIST,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_rst,
  input  logic                  flush,
  input  logic                  write,
  input  logic                  stall_in,
  input  logic                  up_flush,
  input  logic                  in_valid,
  input  logic [INST_W-1:0]     in_inst,
  input  logic [PC_W-1:0]       in_pc,
  input  logic [NSRC*SRC_W-1:0] in_src,
  output logic                  out_valid,
  output logic [INST_W-1:0]     out_inst,
  output logic [PC_W-1:0]       out_pc,
  output logic [NSRC*SRC_W-1:0] out_src,
  output logic                  stall_out,
  output logic                  flush_out,
  output logic [HIST-1:0]       flush_hist,
  output logic [CNT_W-1:0]      hold_cnt,
  output logic                  hold_timeout,
  output logic [31:0]           stat_stall,
  output logic [31:0]           stat_bubble
);
  logic squash;
  logic [HIST-1:0] hist_nx;
  assign squash = stall_rst | flush;
  pipe_field_reg #(.W(1)) u_valid (
    .clk(clk), .rst(rst), .clr(squash), .wen(write), .d(in_valid), .q(out_valid));
  pipe_field_reg #(.W(INST_W), .CLR(INST_W'(NOP_INST))) u_inst (
    .clk(clk), .rst(rst), .clr(squash), .wen(write), .d(in_inst), .q(out_inst));
  pipe_field_reg #(.W(PC_W)) u_pc (
    .clk(clk), .rst(rst), .clr(squash), .wen(write), .d(in_pc), .q(out_pc));
  // operands survive a flush; only a bubble insert wipes them
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    pipe_field_reg #(.W(SRC_W)) u_src (
      .clk(clk), .rst(rst), .clr(stall_rst), .wen(write & ~flush),
      .d(in_src[i*SRC_W +: SRC_W]), .q(out_src[i*SRC_W +: SRC_W]));
  end
  pipe_field_reg #(.W(1)) u_stall (
    .clk(clk), .rst(rst), .clr(1'b0), .wen(write), .d(stall_in), .q(stall_out));
  pipe_field_reg #(.W(1)) u_flush (
    .clk(clk), .rst(rst), .clr(stall_rst), .wen(write), .d(flush), .q(flush_out));
  if (HIST == 1) begin : g_h1
    assign hist_nx = up_flush;
  end else begin : g_hn
    assign hist_nx = {flush_hist[HIST-2:0], up_flush};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) flush_hist <= '0;
    else if (stall_rst) flush_hist <= '0;
    else if (write) flush_hist <= hist_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) hold_cnt <= '0;
    else if (stall_rst || write) hold_cnt <= '0;
    else if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
  assign hold_timeout = hold_cnt >= CNT_W'(HOLD_MAX);
`ifdef PIPE_STATS_EN
  logic [31:0] stall_q, bubble_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (!write) stall_q <= stall_q + 32'd1;
      if (!stall_rst && (flush || (write && !in_valid))) bubble_q <= bubble_q + 32'd1;
    end
  assign stat_stall  = stall_q;
  assign stat_bubble = bubble_q;
`else
  assign stat_stall  = '0;
  assign stat_bubble = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed stimulus, per-cycle compare against a rule-level model.
module tb_pipe_stage_reg;
  localparam bit STATS =
`ifdef PIPE_STATS_EN
    1'b1;
`else
    1'b0;
`endif
  logic clk = 0, rst = 0;
  logic stall_rst = 0, flush = 0, write = 0, stall_in = 0, up_flush = 0, in_valid = 0;
  logic [15:0] in_inst = 0, in_pc = 0;
  logic [31:0] in_src = 0;
  logic out_valid, stall_out, flush_out, hold_timeout;
  logic [15:0] out_inst, out_pc;
  logic [31:0] out_src, stat_stall, stat_bubble;
  logic [2:0] flush_hist;
  logic [3:0] hold_cnt;
  int total = 0, bad = 0;

  pipe_stage_reg #(.HIST(3)) dut (
    .clk(clk), .rst(rst), .stall_rst(stall_rst), .flush(flush), .write(write),
    .stall_in(stall_in), .up_flush(up_flush), .in_valid(in_valid), .in_inst(in_inst),
    .in_pc(in_pc), .in_src(in_src), .out_valid(out_valid), .out_inst(out_inst),
    .out_pc(out_pc), .out_src(out_src), .stall_out(stall_out), .flush_out(flush_out),
    .flush_hist(flush_hist), .hold_cnt(hold_cnt), .hold_timeout(hold_timeout),
    .stat_stall(stat_stall), .stat_bubble(stat_bubble));

  always #5 clk = ~clk;

  // reference state, updated from the priority rules of the stage
  logic m_valid, m_so, m_fo;
  logic [15:0] m_inst, m_pc;
  logic [31:0] m_src, m_ss, m_sb;
  logic [2:0] m_hist;
  int m_hold;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_valid <= 0; m_inst <= 0; m_pc <= 0; m_src <= 0; m_so <= 0; m_fo <= 0;
      m_hist <= 0; m_hold <= 0; m_ss <= 0; m_sb <= 0;
    end else begin
      if (!write) m_ss <= m_ss + 1;
      if (!stall_rst && (flush || (write && !in_valid))) m_sb <= m_sb + 1;
      if (stall_rst) begin
        m_valid <= 0; m_inst <= 0; m_pc <= 0; m_src <= 0; m_fo <= 0; m_hist <= 0; m_hold <= 0;
        if (write) m_so <= stall_in;
      end else if (flush) begin
        m_valid <= 0; m_inst <= 0; m_pc <= 0;
        if (write) begin
          m_so <= stall_in; m_fo <= 1; m_hist <= {m_hist[1:0], up_flush}; m_hold <= 0;
        end else m_hold <= (m_hold < 15) ? m_hold + 1 : 15;
      end else if (!write) m_hold <= (m_hold < 15) ? m_hold + 1 : 15;
      else begin
        m_valid <= in_valid; m_inst <= in_inst; m_pc <= in_pc; m_src <= in_src;
        m_so <= stall_in; m_fo <= 0; m_hist <= {m_hist[1:0], up_flush}; m_hold <= 0;
      end
    end

  logic [138:0] act_v, exp_v;
  assign act_v = {out_valid, out_inst, out_pc, out_src, stall_out, flush_out, flush_hist,
                  hold_cnt, hold_timeout, stat_stall, stat_bubble};
  assign exp_v = {m_valid, m_inst, m_pc, m_src, m_so, m_fo, m_hist, 4'(m_hold), m_hold >= 8,
                  STATS ? m_ss : 32'd0, STATS ? m_sb : 32'd0};

  always @(negedge clk) begin
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL model_cmp t=%0t got=%h want=%h", $time, act_v, exp_v);
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int s0, b0;
  logic [7:0] v;
  initial begin
    cyc(); cyc();
    #2 rst = 1;
    // reset asserted between edges clears everything at once
    in_inst = 16'hBEEF; in_pc = 16'hBEEF; in_src = 32'hBEEFBEEF; in_valid = 1; write = 1; stall_in = 1;
    cyc();
    chk("load_beef", 64'(out_inst), 64'hBEEF);
    #2 rst = 0;
    #1 chk("async_rst", 64'(|act_v), 64'd0);
    chk("rst_inst", 64'(out_inst), 64'd0);
    #2 rst = 1;
    in_inst = 16'h1234; stall_in = 0;
    cyc();
    chk("post_rst_inst", 64'(out_inst), 64'h1234);
    // hold window and timeout
    in_pc = 16'h0040;
    cyc();
    write = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("hold_pc", 64'(out_pc), 64'h0040);
      chk("hold_cnt", 64'(hold_cnt), 64'(i));
      chk("hold_to", 64'(hold_timeout), 64'(i >= 8));
    end
    write = 1;
    cyc();
    chk("hold_clr", 64'(hold_cnt), 64'd0);
    write = 0;
    for (int i = 0; i < 17; i++) cyc();
    chk("hold_sat", 64'(hold_cnt), 64'd15);
    chk("hold_sat_to", 64'(hold_timeout), 64'd1);
    // flush while holding keeps operands and the flush tag
    write = 1; in_src = 32'h0000_00AA; in_inst = 16'h5555; in_pc = 16'h0077;
    cyc();
    write = 0; flush = 1;
    cyc();
    chk("fh_inst", 64'(out_inst), 64'd0);
    chk("fh_pc", 64'(out_pc), 64'd0);
    chk("fh_valid", 64'(out_valid), 64'd0);
    chk("fh_src0", 64'(out_src[15:0]), 64'h00AA);
    chk("fh_fo", 64'(flush_out), 64'd0);
    chk("fh_hold", 64'(hold_cnt), 64'd1);
    write = 1; in_src = 32'h0000_00BB;
    cyc();
    chk("fw_fo", 64'(flush_out), 64'd1);
    chk("fw_src0", 64'(out_src[15:0]), 64'h00AA);
    write = 0;
    cyc();
    chk("fh_fo_held", 64'(flush_out), 64'd1);
    // flush history walk
    flush = 0; stall_rst = 1;
    cyc();
    stall_rst = 0; write = 1; up_flush = 1;
    cyc();
    chk("hist0", 64'(flush_hist), 64'b001);
    up_flush = 0;
    cyc(); chk("hist1", 64'(flush_hist), 64'b010);
    cyc(); chk("hist2", 64'(flush_hist), 64'b100);
    cyc(); chk("hist3", 64'(flush_hist), 64'b000);
    // bubble insert
    up_flush = 1; in_inst = 16'h9999; in_valid = 1;
    cyc();
    stall_rst = 1; stall_in = 1;
    cyc();
    chk("sr_inst", 64'(out_inst), 64'd0);
    chk("sr_src", 64'(out_src), 64'd0);
    chk("sr_valid", 64'(out_valid), 64'd0);
    chk("sr_hist", 64'(flush_hist), 64'd0);
    chk("sr_so", 64'(stall_out), 64'd1);
    stall_rst = 0; stall_in = 0; up_flush = 0;
    cyc();
    // stall and bubble counters
    s0 = int'(stat_stall); b0 = int'(stat_bubble);
    write = 0;
    for (int i = 0; i < 5; i++) cyc();
    write = 1; flush = 1;
    cyc(); cyc();
    flush = 0;
    chk("stat_stall", 64'(int'(stat_stall) - s0), STATS ? 64'd5 : 64'd0);
    chk("stat_bubble", 64'(int'(stat_bubble) - b0), STATS ? 64'd2 : 64'd0);
    // directed mixed vectors, checked by the model every cycle
    for (int i = 0; i < 48; i++) begin
      v = 8'(i * 29 + 7);
      stall_rst = (i % 11) == 5;
      write = v[0] | v[1]; flush = v[2] & v[3]; stall_in = v[4]; up_flush = v[5];
      in_valid = v[6] | v[1]; in_inst = {v, ~v}; in_pc = {~v, v}; in_src = {v, v, ~v, v};
      cyc();
    end
    #6;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
